// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and default sizing for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_ALU = 1'b1
  } arb_state_t;

  localparam int DEF_W          = 32;
  localparam int DEF_NU_REG     = 5;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and LSU writebacks onto the single register-file write port.
// LSU normally wins; a starved ALU is forced through after STARVE_MAX losses.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int nu_reg     = DEF_NU_REG,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [nu_reg-1:0] alu_addr_i,
  input  logic [W-1:0]      alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [nu_reg-1:0] lsu_addr_i,
  input  logic [W-1:0]      lsu_data_i,
  output logic              lsu_ready_o,
  output logic              wr_en_d_o,
  output logic [nu_reg-1:0] addr_d_o,
  output logic [W-1:0]      data_d_o,
  output logic              force_alu_o
);

  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              wr_en_q, wr_en_d;
  logic [nu_reg-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]      wr_data_q, wr_data_d;

  // State register and write-port registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= NORMAL;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Grant decode; nothing is accepted while reset is held
  always_comb begin
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        FORCE_ALU: begin
          alu_ready_o = alu_valid_i;
          lsu_ready_o = lsu_valid_i & ~alu_valid_i;
        end
        default: begin
          lsu_ready_o = lsu_valid_i;
          alu_ready_o = alu_valid_i & ~lsu_valid_i;
        end
      endcase
    end
  end

  always_comb begin
    starve_d = '0;
    if (alu_valid_i && !alu_ready_o)
      starve_d = (starve_q == SMAX) ? starve_q : starve_q + CW'(1);
  end

  // Next-state: enter FORCE_ALU the edge the loss count reaches the limit
  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:    if (starve_d == SMAX) state_d = FORCE_ALU;
      FORCE_ALU: if (!alu_valid_i || alu_ready_o) state_d = NORMAL;
      default:   state_d = NORMAL;
    endcase
  end

  // Writes to x0 are consumed but never assert the write enable
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_ready_o) begin
      wr_en_d   = (alu_addr_i != '0);
      wr_addr_d = alu_addr_i;
      wr_data_d = alu_data_i;
    end else if (lsu_ready_o) begin
      wr_en_d   = (lsu_addr_i != '0);
      wr_addr_d = lsu_addr_i;
      wr_data_d = lsu_data_i;
    end
  end

  assign wr_en_d_o   = wr_en_q;
  assign addr_d_o    = wr_addr_q;
  assign data_d_o    = wr_data_q;
  assign force_alu_o = (state_q == FORCE_ALU);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios plus randomized hold-until-accepted traffic against a priority/starvation model.
module tb_rf_wb_arbiter;

  localparam int W    = 32;
  localparam int NR   = 5;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_v, lsu_v;
  logic [NR-1:0] alu_a, lsu_a;
  logic [W-1:0]  alu_d, lsu_d;
  logic          alu_ready_o, lsu_ready_o, wr_en_d_o, force_alu_o;
  logic [NR-1:0] addr_d_o;
  logic [W-1:0]  data_d_o;

  rf_wb_arbiter #(.W(W), .nu_reg(NR), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_v), .alu_addr_i(alu_a), .alu_data_i(alu_d), .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_v), .lsu_addr_i(lsu_a), .lsu_data_i(lsu_d), .lsu_ready_o(lsu_ready_o),
    .wr_en_d_o(wr_en_d_o), .addr_d_o(addr_d_o), .data_d_o(data_d_o), .force_alu_o(force_alu_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: ALU loss streak, forced flag, expected write port
  int            losses = 0;
  bit            forced = 0;
  bit            m_wr   = 0;
  logic [NR-1:0] m_addr = '0;
  logic [W-1:0]  m_data = '0;
  bit            g_alu, g_lsu;

  task automatic cycle();
    int nl;
    @(negedge clk);
    g_alu = !rst && alu_v && (forced || !lsu_v);
    g_lsu = !rst && lsu_v && !g_alu;
    chk("alu_ready", alu_ready_o, g_alu);
    chk("lsu_ready", lsu_ready_o, g_lsu);
    chk("force_alu", force_alu_o, forced);
    @(posedge clk);
    if (rst) begin
      losses = 0; forced = 0; m_wr = 0; m_addr = '0; m_data = '0;
    end else begin
      nl = (alu_v && !g_alu) ? ((losses + 1 > SMAX) ? SMAX : losses + 1) : 0;
      if (forced) forced = alu_v && !g_alu;
      else        forced = (nl == SMAX);
      losses = nl;
      m_wr = 0;
      if (g_alu)      begin m_wr = (alu_a != 0); m_addr = alu_a; m_data = alu_d; end
      else if (g_lsu) begin m_wr = (lsu_a != 0); m_addr = lsu_a; m_data = lsu_d; end
    end
    #1;
    chk("wr_en", wr_en_d_o, m_wr);
    chk("addr", addr_d_o, m_addr);
    chk("data", data_d_o, m_data);
  endtask

  logic [NR-1:0] sv_a;
  logic [W-1:0]  sv_d;
  bit            alu_pend, lsu_pend;

  initial begin
    rst = 1; alu_v = 0; lsu_v = 0; alu_a = '0; lsu_a = '0; alu_d = '0; lsu_d = '0;
    cycle(); cycle();
    chk("rst_wr_en", wr_en_d_o, 0);
    chk("rst_addr", addr_d_o, 0);
    chk("rst_data", data_d_o, 0);
    chk("rst_force", force_alu_o, 0);
    rst = 0;

    // LSU only
    lsu_v = 1; lsu_a = 5; lsu_d = 32'hDEADBEEF;
    cycle();
    chk("lsu_only_wr", wr_en_d_o, 1);
    chk("lsu_only_addr", addr_d_o, 5);
    chk("lsu_only_data", data_d_o, 32'hDEADBEEF);
    lsu_v = 0;

    // Collision: LSU first, then ALU
    alu_v = 1; alu_a = 3; alu_d = 32'hAAAA0003;
    lsu_v = 1; lsu_a = 7; lsu_d = 32'hBBBB0007;
    cycle();
    chk("coll_first_addr", addr_d_o, 7);
    lsu_v = 0;
    cycle();
    chk("coll_second_addr", addr_d_o, 3);
    chk("coll_second_data", data_d_o, 32'hAAAA0003);
    alu_v = 0;
    cycle();

    // Starvation: four LSU wins, then ALU forced through
    alu_v = 1; alu_a = 9; alu_d = 32'h0000A1A1;
    lsu_v = 1; lsu_a = 10; lsu_d = 32'h0000B2B2;
    repeat (4) cycle();
    chk("starve_force_set", force_alu_o, 1);
    chk("starve_last_lsu", addr_d_o, 10);
    cycle();
    chk("starve_alu_addr", addr_d_o, 9);
    chk("starve_force_clr", force_alu_o, 0);
    alu_v = 0; lsu_v = 0;
    cycle();

    // Write to x0 is consumed without a write
    alu_v = 1; alu_a = 0; alu_d = 32'h1234;
    cycle();
    chk("x0_wr_en", wr_en_d_o, 0);
    alu_v = 0;
    cycle();

    // Reset while forced, both valid
    alu_v = 1; alu_a = 4; alu_d = 32'h44;
    lsu_v = 1; lsu_a = 6; lsu_d = 32'h66;
    repeat (4) cycle();
    chk("mid_force_set", force_alu_o, 1);
    rst = 1;
    cycle();
    chk("mid_rst_wr_en", wr_en_d_o, 0);
    chk("mid_rst_force", force_alu_o, 0);
    rst = 0;
    repeat (3) cycle();
    chk("post_rst_no_force", force_alu_o, 0);
    cycle();
    chk("post_rst_force", force_alu_o, 1);
    cycle();
    chk("post_rst_alu_addr", addr_d_o, 4);
    alu_v = 0; lsu_v = 0;
    cycle();

    // Idle: write port holds
    sv_a = addr_d_o; sv_d = data_d_o;
    repeat (10) begin
      cycle();
      chk("idle_wr_en", wr_en_d_o, 0);
      chk("idle_addr", addr_d_o, sv_a);
      chk("idle_data", data_d_o, sv_d);
    end

    // Random traffic; requesters hold until accepted, reset drops pending
    alu_pend = 0; lsu_pend = 0;
    repeat (600) begin
      if (!alu_pend && ($urandom_range(0, 3) != 0)) begin
        alu_pend = 1; alu_a = NR'($urandom_range(0, 31)); alu_d = $urandom;
      end
      if (!lsu_pend && ($urandom_range(0, 3) != 0)) begin
        lsu_pend = 1; lsu_a = NR'($urandom_range(0, 31)); lsu_d = $urandom;
      end
      alu_v = alu_pend; lsu_v = lsu_pend;
      rst = ($urandom_range(0, 49) == 0);
      cycle();
      if (rst) begin alu_pend = 0; lsu_pend = 0; end
      if (g_alu) alu_pend = 0;
      if (g_lsu) lsu_pend = 0;
    end
    rst = 0; alu_v = 0; lsu_v = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
  - W, 32, data width.
  - nu_reg, 5, register address width.
  - STARVE_MAX, 4, consecutive ALU losses before ALU is forced.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk_i, in, 1, sole clock; all state updates on rising edge.
  - rst_i, in, 1, synchronous, active-high reset.
  - alu_valid_i, in, 1, ALU writeback request.
  - alu_addr_i, in, nu_reg, ALU destination register.
  - alu_data_i, in, W, ALU result.
  - alu_ready_o, out, 1, ALU request accepted this cycle.
  - lsu_valid_i, in, 1, load writeback request.
  - lsu_addr_i, in, nu_reg, load destination register.
  - lsu_data_i, in, W, load data.
  - lsu_ready_o, out, 1, LSU request accepted this cycle.
  - wr_en_d_o, out, 1, register-file write enable.
  - addr_d_o, out, nu_reg, register-file write address.
  - data_d_o, out, W, register-file write data.
  - force_alu_o, out, 1, arbiter is in FORCE_ALU state.

Function
REQ-003 A request SHALL be accepted in a cycle where valid and ready are both high; at most one request SHALL be accepted per cycle.
REQ-004 Requesters SHALL hold valid, addr and data stable until accepted; the arbiter SHALL NOT buffer a losing request.
REQ-005 alu_ready_o and lsu_ready_o SHALL be combinational from valids and current state, and never both high.
REQ-006 State NORMAL: lsu_ready_o = lsu_valid_i; alu_ready_o = alu_valid_i & ~lsu_valid_i.
REQ-007 State FORCE_ALU: alu_ready_o = alu_valid_i; lsu_ready_o = lsu_valid_i & ~alu_valid_i.
REQ-008 Starve counter (width clog2(STARVE_MAX)+1) SHALL increment each cycle alu_valid_i=1 and alu_ready_o=0, saturating at STARVE_MAX.
REQ-009 The counter SHALL clear on ALU acceptance or when alu_valid_i=0.
REQ-010 NORMAL -> FORCE_ALU SHALL occur on the edge at which the counter reaches STARVE_MAX.
REQ-011 FORCE_ALU -> NORMAL SHALL occur on the edge following ALU acceptance or a cycle with alu_valid_i=0.
REQ-012 Write-port outputs SHALL be registered; latency from acceptance to wr_en_d_o=1 SHALL be exactly 1 cycle.
REQ-013 An accepted request with addr=0 SHALL be consumed (ready high) with wr_en_d_o=0 the next cycle.
REQ-014 With no acceptance, wr_en_d_o SHALL be 0 the next cycle; addr_d_o/data_d_o SHALL hold their previous values.
REQ-015 Both requesters targeting the same address: each SHALL be written in grant order; last granted wins, with no merging.
REQ-016 force_alu_o SHALL be 1 exactly when state is FORCE_ALU.

Reset
REQ-017 While rst_i=1 at a clock edge, all outputs and state SHALL reset:
  - wr_en_d_o=0, addr_d_o=0, data_d_o=0.
  - state=NORMAL, starve counter=0, force_alu_o=0.
REQ-018 During reset, alu_ready_o and lsu_ready_o SHALL be 0 and no request SHALL be accepted.
REQ-019 A request pending when reset asserts SHALL be dropped; the requester re-presents it after reset.

Structure
REQ-020 A shared package SHALL hold:
  - the arb_state_t enum (NORMAL, FORCE_ALU);
  - default constants W=32, nu_reg=5, STARVE_MAX=4.
REQ-021 The block SHALL be a single module with no sub-modules.
REQ-022 wr_en_d_o/addr_d_o/data_d_o SHALL connect directly to the register file write port (wr_en_d, addr_d, data_d).

Verification
REQ-023 The bench SHALL cover:
  - LSU only: lsu_valid=1, addr=5, data=0xDEADBEEF -> lsu_ready=1 same cycle; next cycle wr_en_d_o=1, addr_d_o=5, data_d_o=0xDEADBEEF.
  - Collision: both valid (ALU addr=3, LSU addr=7) -> cycle 0 LSU granted; LSU drops -> cycle 1 ALU granted; writes to 7 then 3 on consecutive cycles.
  - Starvation: LSU valid continuously, ALU valid continuously -> 4 LSU grants, force_alu_o=1, ALU granted on 5th cycle, NORMAL the cycle after.
  - x0 drop: ALU valid, addr=0, data=0x1234 -> alu_ready=1; next cycle wr_en_d_o=0.
  - Reset mid-operation: rst_i=1 during FORCE_ALU with both valid -> both ready=0; next edge wr_en_d_o=0, force_alu_o=0, counter=0.
  - Idle: no valids for 10 cycles -> wr_en_d_o=0 throughout, addr_d_o/data_d_o unchanged.
